// File: rtl/jk_button_encoder.sv
// rtl/jk_button_encoder.sv - push-button to JK command encoder with debounce and pair-to-toggle
//
// Turns two raw push-buttons into single-cycle J/K command pulses for a JK flip-flop.
// Each button is synchronised (two flops) and debounced. A second press inside the
// pair window merges both presses into one toggle command (J=K=1). A model of the
// flip-flop output is kept alongside.
//
// Optional feature macro: JK_AUTOREPEAT_EN (auto-repeat of the last command while held).
//
// Ports:
//   clock     in  system clock, all logic on posedge
//   reset_n   in  asynchronous active-low reset
//   btn_set   in  raw set button, active-high, asynchronous
//   btn_clr   in  raw clear button, active-high, asynchronous
//   j         out J command, registered
//   k         out K command, registered
//   cmd_valid out one-cycle strobe, high whenever j or k is high
//   q_model   out expected flip-flop output after each command

module jk_button_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PAIR_CYCLES     = 8
`ifdef JK_AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 16
`endif
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_set,
  input  logic btn_clr,
  output logic j,
  output logic k,
  output logic cmd_valid,
  output logic q_model
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PAIR_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PAIR_LAST = PW'(PAIR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_PAIR,
    S_EMIT,
    S_WAIT_RELEASE
  } state_t;

  // Bit 1 is the set button, bit 0 the clear button, so a one-hot button
  // vector doubles as its own {j,k} command.
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q, deb_d;
  logic [1:0]    deb_prev_q;
  logic [DW-1:0] db_cnt_q [2];
  logic [DW-1:0] db_cnt_d [2];
  logic [1:0]    rise;

  state_t        state_q, state_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [1:0]    first_q, first_d;
  logic [PW-1:0] pair_cnt_q, pair_cnt_d;

  logic          j_q, j_d;
  logic          k_q, k_d;
  logic          valid_q, valid_d;
  logic          q_model_q, q_model_d;

  // ------------------------------------------------------------------
  // Two-flop synchronisers
  // ------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {btn_set, btn_clr};
      sync2_q <= sync1_q;
    end
  end

  // ------------------------------------------------------------------
  // Debounce: the debounced level follows the synced level only after it
  // has differed for DEBOUNCE_CYCLES consecutive cycles.
  // ------------------------------------------------------------------
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      deb_d[b]    = deb_q[b];
      db_cnt_d[b] = '0;
      if (sync2_q[b] != deb_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          deb_d[b] = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      deb_q      <= 2'b00;
      deb_prev_q <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        db_cnt_q[b] <= '0;
      end
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int b = 0; b < 2; b++) begin
        db_cnt_q[b] <= db_cnt_d[b];
      end
    end
  end

  assign rise = deb_q & ~deb_prev_q;

  // ------------------------------------------------------------------
  // Auto-repeat bookkeeping
  // ------------------------------------------------------------------
`ifdef JK_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  // The EMIT cycle itself is one cycle of the repeat period, and the counter
  // starts at zero on the first WAIT_RELEASE cycle, hence the -2.
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 2);

  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_stop_q, rpt_stop_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt_q  <= '0;
      rpt_stop_q <= 1'b0;
    end else begin
      rpt_cnt_q  <= rpt_cnt_d;
      rpt_stop_q <= rpt_stop_d;
    end
  end
`endif

  // ------------------------------------------------------------------
  // Command FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= 2'b00;
      first_q    <= 2'b00;
      pair_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      first_q    <= first_d;
      pair_cnt_q <= pair_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    first_d    = first_q;
    pair_cnt_d = pair_cnt_q;
`ifdef JK_AUTOREPEAT_EN
    rpt_cnt_d  = rpt_cnt_q;
    rpt_stop_d = rpt_stop_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rise == 2'b11) begin
          cmd_d   = 2'b11;
          state_d = S_EMIT;
        end else if (rise != 2'b00) begin
          first_d    = rise;
          pair_cnt_d = '0;
          state_d    = S_WAIT_PAIR;
        end
      end

      S_WAIT_PAIR: begin
        // Priority: second button, then release of the first, then timeout.
        if ((rise & ~first_q) != 2'b00) begin
          cmd_d   = 2'b11;
          state_d = S_EMIT;
        end else if ((deb_q & first_q) == 2'b00) begin
          cmd_d   = first_q;
          state_d = S_EMIT;
        end else if (pair_cnt_q == PAIR_LAST) begin
          cmd_d   = first_q;
          state_d = S_EMIT;
        end else begin
          pair_cnt_d = pair_cnt_q + PW'(1);
        end
      end

      S_EMIT: begin
        state_d = S_WAIT_RELEASE;
`ifdef JK_AUTOREPEAT_EN
        rpt_cnt_d = '0;
`endif
      end

      S_WAIT_RELEASE: begin
        if (deb_q == 2'b00) begin
          state_d = S_IDLE;
`ifdef JK_AUTOREPEAT_EN
          rpt_stop_d = 1'b0;
        end else if (!rpt_stop_q && (deb_q == cmd_q)) begin
          if (rpt_cnt_q == RPT_LAST) begin
            rpt_cnt_d = '0;
            state_d   = S_EMIT;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RW'(1);
          end
        end else begin
          // Once the held combination changes, repeating stays off until
          // both buttons are released.
          rpt_stop_d = 1'b1;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Registered outputs: asserted in the cycle the FSM sits in EMIT.
  // cmd_d is always non-zero on any transition into EMIT.
  // ------------------------------------------------------------------
  always_comb begin
    valid_d = (state_d == S_EMIT);
    j_d     = valid_d & cmd_d[1];
    k_d     = valid_d & cmd_d[0];
  end

  // The flip-flop samples j/k on the edge that ends EMIT; the model follows.
  always_comb begin
    q_model_d = q_model_q;
    if (state_q == S_EMIT) begin
      case (cmd_q)
        2'b10:   q_model_d = 1'b1;
        2'b01:   q_model_d = 1'b0;
        2'b11:   q_model_d = ~q_model_q;
        default: q_model_d = q_model_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      j_q       <= 1'b0;
      k_q       <= 1'b0;
      valid_q   <= 1'b0;
      q_model_q <= 1'b0;
    end else begin
      j_q       <= j_d;
      k_q       <= k_d;
      valid_q   <= valid_d;
      q_model_q <= q_model_d;
    end
  end

  assign j         = j_q;
  assign k         = k_q;
  assign cmd_valid = valid_q;
  assign q_model   = q_model_q;

endmodule

// File: tb/tb_jk_button_encoder.sv
// tb/tb_jk_button_encoder.sv - self-checking bench for jk_button_encoder

module tb_jk_button_encoder;

  logic clock;
  logic reset_n;
  logic btn_set;
  logic btn_clr;
  logic j;
  logic k;
  logic cmd_valid;
  logic q_model;

  typedef struct {
    logic [1:0] cmd;
    logic       q_after;
    int         edge_no;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  logic q_exp     = 1'b0;
  logic q_pend    = 1'b0;
  logic q_want    = 1'b0;

  jk_button_encoder dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .btn_set   (btn_set),
    .btn_clr   (btn_clr),
    .j         (j),
    .k         (k),
    .cmd_valid (cmd_valid),
    .q_model   (q_model)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected pulse: cmd, the cycle count at which it must appear, and the
  // resulting flip-flop state computed from the bench's own model.
  task automatic expect_cmd(input logic [1:0] cmd, input int edge_no);
    case (cmd)
      2'b10:   q_exp = 1'b1;
      2'b01:   q_exp = 1'b0;
      default: q_exp = ~q_exp;
    endcase
    sb.push_back('{cmd, q_exp, edge_no});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  // Output monitor: every pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (q_pend) begin
      check("q_model_after_cmd", q_model, q_want);
      q_pend = 1'b0;
    end
    check("valid_eq_j_or_k", cmd_valid, j | k);
    if (cmd_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", cmd_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("pulse_cmd", {j, k}, e.cmd);
        if (e.edge_no >= 0) check("pulse_edge", cyc, e.edge_no);
        q_want = e.q_after;
        q_pend = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    btn_set = 1'b0;
    btn_clr = 1'b0;
    cycles(3);
    check("rst_j", j, 1'b0);
    check("rst_k", k, 1'b0);
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_q_model", q_model, 1'b0);
    reset_n = 1'b1;
    cycles(2);

    // Single set press held past the pair window: pulse at edge 15.
    btn_set = 1'b1;
    expect_cmd(2'b10, cyc + 15);
    cycles(40);
    btn_set = 1'b0;
    wait_drain(5);
    cycles(12);

    // Bouncing clear button, then a clean hold.
    for (int i = 0; i < 3; i++) begin
      btn_clr = 1'b1;
      cycles(2);
      btn_clr = 1'b0;
      cycles(2);
    end
    btn_clr = 1'b1;
    expect_cmd(2'b01, cyc + 15);
    cycles(30);
    btn_clr = 1'b0;
    wait_drain(5);
    cycles(12);

    // Set then clear 3 cycles later: one toggle, pulse on the clear rise.
    btn_set = 1'b1;
    expect_cmd(2'b11, cyc + 10);
    cycles(3);
    btn_clr = 1'b1;
    cycles(30);
    btn_set = 1'b0;
    btn_clr = 1'b0;
    wait_drain(5);
    cycles(12);

    // Short set press released inside the pair window: pulse on release detection.
    btn_set = 1'b1;
    expect_cmd(2'b10, cyc + 13);
    cycles(6);
    btn_set = 1'b0;
    cycles(20);
    wait_drain(5);

    // A press while another button is still held is ignored.
    btn_clr = 1'b1;
    expect_cmd(2'b01, cyc + 15);
    cycles(20);
    btn_set = 1'b1;
    cycles(10);
    btn_set = 1'b0;
    cycles(15);
    btn_clr = 1'b0;
    cycles(12);
    btn_set = 1'b1;
    expect_cmd(2'b10, cyc + 15);
    cycles(25);
    btn_set = 1'b0;
    wait_drain(5);
    cycles(12);

    // Reset while waiting for a pair: outputs clear at once, nothing emitted later.
    btn_set = 1'b1;
    cycles(9);
    reset_n = 1'b0;
    #1;
    q_exp = 1'b0;
    check("midrst_j", j, 1'b0);
    check("midrst_k", k, 1'b0);
    check("midrst_valid", cmd_valid, 1'b0);
    check("midrst_q_model", q_model, 1'b0);
    btn_set = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(30);
    check("no_pending_expectations", sb.size(), 0);
    check("q_model_final", q_model, q_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_button_encoder.md
Name: jk_button_encoder

Overview:
- Upstream stage of the JK flip-flop: turns two raw push-buttons (set, clear) into clean single-cycle j/k command pulses.
- Synchronises and debounces each button.
- Pressing both buttons within a short window combines them into one toggle command.
- Keeps a model of the expected flip-flop state for display and self-check.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles needed before a debounced level changes; must be at least 1.
- PAIR_CYCLES, 8: window after the first press during which a second press combines into a toggle; must be at least 1.
- REPEAT_CYCLES, 16: auto-repeat period; only used when JK_AUTOREPEAT_EN is defined.

Ports:
- clock, input, 1: single system clock; all logic on posedge.
- reset_n, input, 1: asynchronous, active-low reset.
- btn_set, input, 1: raw set button, active-high, asynchronous to clock.
- btn_clr, input, 1: raw clear button, active-high, asynchronous to clock.
- j, output, 1: J command to the JK flip-flop, registered.
- k, output, 1: K command to the JK flip-flop, registered.
- cmd_valid, output, 1: one-cycle strobe, high in every cycle where j or k is high.
- q_model, output, 1: expected JK flip-flop output after each command.

Behaviour:
- Reset (reset_n=0, takes effect immediately, asynchronously):
  - j=0, k=0, cmd_valid=0, q_model=0.
  - Sync flops=0, debounced levels=0, all counters=0, FSM in IDLE.
- Synchroniser: two flops per button. The synced level lags the raw level by 2 cycles.
- Debounce, per button:
  - Counter of width $clog2(DEBOUNCE_CYCLES+1).
  - While synced != debounced, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, debounced <= synced and the counter clears.
  - Any cycle with synced == debounced clears the counter.
  - A rise is a cycle where debounced=1 and its previous value was 0.
- FSM states: IDLE, WAIT_PAIR, EMIT, WAIT_RELEASE.
  - IDLE, both rises in the same cycle: latch cmd=11, go to EMIT.
  - IDLE, one rise only: latch that button as first, clear the pair timer, go to WAIT_PAIR.
  - WAIT_PAIR, other button rises: cmd=11, go to EMIT.
  - WAIT_PAIR, first button's debounced level falls: cmd = first button's command (set=10, clr=01), go to EMIT.
  - WAIT_PAIR, timer == PAIR_CYCLES-1: cmd = first button's command, go to EMIT.
  - WAIT_PAIR, no event: timer increments.
  - WAIT_PAIR priority: second rise, then release, then timeout.
  - EMIT: lasts exactly one cycle. {j,k}=cmd and cmd_valid=1, driven from registers. Go to WAIT_RELEASE.
  - WAIT_RELEASE: go to IDLE when both debounced levels are 0. Rises seen in this state are ignored.
- Output rules:
  - j, k and cmd_valid are 0 in every non-EMIT cycle.
  - {j,k}=00 is never emitted with cmd_valid=1.
- q_model updates on the clock edge that ends the EMIT cycle, the same edge on which the flip-flop samples j/k:
  - 10 -> 1
  - 01 -> 0
  - 11 -> ~q_model
- Single-press latency, with the button held past the pair window: the cmd_valid cycle begins 2+DEBOUNCE_CYCLES+PAIR_CYCLES+1 edges after the raw rise is first sampled.
- Buttons held through reset release: debounced restarts at 0, so a held button registers as a new press after debounce. This is intended.
- Reset mid-operation: any latched command is discarded and no pulse is emitted for it.

Optional Feature:
- Macro: JK_AUTOREPEAT_EN.
- Defined:
  - In WAIT_RELEASE, while the same button combination that produced the last command stays debounced-high, a repeat counter re-enters EMIT every REPEAT_CYCLES cycles with the same cmd.
  - Any change in the combination stops repeating.
- Undefined: exactly one command per press; no repeat counter is instantiated.

Test Plan:
- Defaults used: DEBOUNCE_CYCLES=4, PAIR_CYCLES=8.
- Reset, then hold btn_set=1 for 40 cycles -> exactly one cmd_valid pulse with j=1, k=0, at edge 15 after the raw rise; q_model 0->1.
- btn_clr bounces (toggling every 2 cycles for 12 cycles), then held high for 30 cycles -> exactly one pulse, j=0, k=1; no pulse during the bounce; q_model->0.
- btn_set rises, btn_clr rises 3 cycles later, both held -> one pulse j=1, k=1; q_model inverts; no separate set or clr pulse.
- btn_set held 6 cycles after debounce, then released (before the pair window ends) -> one set pulse on release detection; next press accepted only after both buttons are low.
- reset_n pulsed low during WAIT_PAIR -> j, k, cmd_valid, q_model = 0 immediately; buttons released after reset -> no pulse.
- With JK_AUTOREPEAT_EN, btn_set held 60 cycles -> first pulse, then pulses every 16 cycles until release. Without the macro -> a single pulse.
